// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared defaults and arbiter state encoding for the
//                two-port data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_XLEN      = 32;
    localparam int DMEM_DEPTH     = 64;
    localparam int DMEM_MAX_BURST = 4;

    // Ownership state: who was granted on the previous cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_rr_select
//  Description : Combinational grant decision for the data-memory arbiter.
//                Applies the tie-break (port !last_served wins from IDLE)
//                and the burst limit (owner keeps the memory while the
//                other port is quiet, or until MAX_BURST consecutive grants
//                while the other port is requesting).
//  Ports       : i_state       - current ownership state
//                i_cnt         - consecutive grants to the current owner
//                i_last_served - port that owned the memory most recently
//                i_req0/i_req1 - port requests
//                o_gnt0/o_gnt1 - one-hot (or empty) grant
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_rr_select
    import dmem_pkg::*;
#(
    parameter int MAX_BURST = DMEM_MAX_BURST,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  state_t             i_state,
    input  logic [CNT_W-1:0]   i_cnt,
    input  logic               i_last_served,
    input  logic               i_req0,
    input  logic               i_req1,
    output logic               o_gnt0,
    output logic               o_gnt1
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_BURST);

    logic w_below_max;

    assign w_below_max = (i_cnt < C_MAX);

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        case (i_state)
            IDLE: begin
                if (i_req0 && i_req1) begin
                    o_gnt0 = i_last_served;
                    o_gnt1 = ~i_last_served;
                end else begin
                    o_gnt0 = i_req0;
                    o_gnt1 = i_req1;
                end
            end
            OWN0: begin
                // Owner keeps going unless the other side is waiting and
                // the burst budget is spent; otherwise hand over directly.
                if (i_req0 && (!i_req1 || w_below_max)) begin
                    o_gnt0 = 1'b1;
                end else begin
                    o_gnt1 = i_req1;
                end
            end
            OWN1: begin
                if (i_req1 && (!i_req0 || w_below_max)) begin
                    o_gnt1 = 1'b1;
                end else begin
                    o_gnt0 = i_req0;
                end
            end
            default: begin
                o_gnt0 = 1'b0;
                o_gnt1 = 1'b0;
            end
        endcase
    end

endmodule : dmem_rr_select
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter (port 0 = core, port 1 = loader) in front
//                of a single-port data memory with combinational read.
//                Each granted access completes in one cycle; read data
//                returns one cycle later on rvalid_p. Out-of-range accesses
//                (addr >= DEPTH) never write and report rerr_p.
//  Ports       : clock, reset            - clock / sync active-high reset
//                req_p, we_p, addr_p,
//                wdata_p                 - request group, p in {0,1}
//                gnt_p, rvalid_p,
//                rdata_p, rerr_p         - response group, p in {0,1}
//                mem_address, mem_write_data, mem_write_enable,
//                mem_read_data           - memory side
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int XLEN      = DMEM_XLEN,
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int MAX_BURST = DMEM_MAX_BURST
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               req_0,
    input  logic               we_0,
    input  logic [XLEN-1:0]    addr_0,
    input  logic [XLEN-1:0]    wdata_0,
    input  logic               req_1,
    input  logic               we_1,
    input  logic [XLEN-1:0]    addr_1,
    input  logic [XLEN-1:0]    wdata_1,

    output logic               gnt_0,
    output logic               rvalid_0,
    output logic [XLEN-1:0]    rdata_0,
    output logic               rerr_0,
    output logic               gnt_1,
    output logic               rvalid_1,
    output logic [XLEN-1:0]    rdata_1,
    output logic               rerr_1,

    output logic [XLEN-1:0]    mem_address,
    output logic [XLEN-1:0]    mem_write_data,
    output logic               mem_write_enable,
    input  logic [XLEN-1:0]    mem_read_data
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [XLEN-1:0]  C_DEPTH = XLEN'(DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_last_served;
    logic               w_last_nxt;

    logic               w_sel0;
    logic               w_sel1;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_inr0;
    logic               w_inr1;

    logic               r_rvalid0;
    logic               r_rvalid1;
    logic               r_rerr0;
    logic               r_rerr1;
    logic [XLEN-1:0]    r_rdata0;
    logic [XLEN-1:0]    r_rdata1;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    dmem_rr_select #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_rr_select (
        .i_state       (r_state),
        .i_cnt         (r_cnt),
        .i_last_served (r_last_served),
        .i_req0        (req_0),
        .i_req1        (req_1),
        .o_gnt0        (w_sel0),
        .o_gnt1        (w_sel1)
    );

    // Requests are ignored entirely while reset is held.
    assign w_gnt0 = w_sel0 & ~reset;
    assign w_gnt1 = w_sel1 & ~reset;
    assign gnt_0  = w_gnt0;
    assign gnt_1  = w_gnt1;

    assign w_inr0 = (addr_0 < C_DEPTH);
    assign w_inr1 = (addr_1 < C_DEPTH);

    // ------------------------------------------------------------------
    // Memory-side mux
    // ------------------------------------------------------------------
    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        if (w_gnt0) begin
            mem_address      = addr_0;
            mem_write_data   = wdata_0;
            mem_write_enable = we_0 & w_inr0;
        end else if (w_gnt1) begin
            mem_address      = addr_1;
            mem_write_data   = wdata_1;
            mem_write_enable = we_1 & w_inr1;
        end
    end

    // ------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_last_served <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_last_served <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last_served;
        if (w_gnt0) begin
            if (r_state == OWN0) begin
                // Saturate rather than wrap so a lone streamer never
                // appears to have a fresh budget.
                if (r_cnt != C_MAX) begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end else begin
                if (r_state == OWN1) begin
                    w_last_nxt = 1'b1;
                end
                w_state_nxt = OWN0;
                w_cnt_nxt   = C_ONE;
            end
        end else if (w_gnt1) begin
            if (r_state == OWN1) begin
                if (r_cnt != C_MAX) begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end else begin
                if (r_state == OWN0) begin
                    w_last_nxt = 1'b0;
                end
                w_state_nxt = OWN1;
                w_cnt_nxt   = C_ONE;
            end
        end else if (r_state == OWN0) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_last_nxt  = 1'b0;
        end else if (r_state == OWN1) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_last_nxt  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response registers (one-cycle read latency)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rerr0   <= 1'b0;
            r_rdata0  <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~we_0;
            r_rerr0   <= w_gnt0 & ~w_inr0;
            if (w_gnt0 && !we_0) begin
                r_rdata0 <= w_inr0 ? mem_read_data : '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid1 <= 1'b0;
            r_rerr1   <= 1'b0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid1 <= w_gnt1 & ~we_1;
            r_rerr1   <= w_gnt1 & ~w_inr1;
            if (w_gnt1 && !we_1) begin
                r_rdata1 <= w_inr1 ? mem_read_data : '0;
            end
        end
    end

    // A reset arriving while a response is on the bus drops it at once.
    assign rvalid_0 = r_rvalid0 & ~reset;
    assign rerr_0   = r_rerr0   & ~reset;
    assign rdata_0  = r_rdata0;
    assign rvalid_1 = r_rvalid1 & ~reset;
    assign rerr_1   = r_rerr1   & ~reset;
    assign rdata_1  = r_rdata1;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. Directed vectors with
//                hand-computed expectations, followed by random traffic,
//                all cross-checked against a grant/streak reference model
//                and a reference copy of the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int XLEN      = 32;
    localparam int DEPTH     = 64;
    localparam int MAX_BURST = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req [2];
    logic              we  [2];
    logic [XLEN-1:0]   addr  [2];
    logic [XLEN-1:0]   wdata [2];

    logic              gnt_0, gnt_1, rvalid_0, rvalid_1, rerr_0, rerr_1;
    logic [XLEN-1:0]   rdata_0, rdata_1;
    logic [XLEN-1:0]   mem_address, mem_write_data, mem_read_data;
    logic              mem_write_enable;

    logic [XLEN-1:0]   env_mem [DEPTH] = '{default: '0};

    always #5 clock = ~clock;

    dmem_arbiter #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req_0            (req[0]),
        .we_0             (we[0]),
        .addr_0           (addr[0]),
        .wdata_0          (wdata[0]),
        .req_1            (req[1]),
        .we_1             (we[1]),
        .addr_1           (addr[1]),
        .wdata_1          (wdata[1]),
        .gnt_0            (gnt_0),
        .rvalid_0         (rvalid_0),
        .rdata_0          (rdata_0),
        .rerr_0           (rerr_0),
        .gnt_1            (gnt_1),
        .rvalid_1         (rvalid_1),
        .rdata_1          (rdata_1),
        .rerr_1           (rerr_1),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    // Environment memory driven only by what the DUT actually does.
    assign mem_read_data = (mem_address < XLEN'(DEPTH)) ? env_mem[mem_address[5:0]] : '0;
    always @(posedge clock) begin
        if (mem_write_enable && (mem_address < XLEN'(DEPTH))) begin
            env_mem[mem_address[5:0]] <= mem_write_data;
        end
    end

    // ------------------------------------------------------------------
    // Vector record
    // ------------------------------------------------------------------
    typedef struct {
        bit              tbl;
        bit              rst;
        bit              r0, w0;
        logic [XLEN-1:0] a0, d0;
        bit              r1, w1;
        logic [XLEN-1:0] a1, d1;
        bit [1:0]        g;      // {gnt_1,gnt_0} expected this cycle
        bit              mwe;
        bit [1:0]        rv;     // responses expected after the edge
        bit [1:0]        re;
        bit [1:0]        crd;    // which rdata ports to compare
        logic [XLEN-1:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(bit rst,
                                bit r0, bit w0, logic [XLEN-1:0] a0, logic [XLEN-1:0] d0,
                                bit r1, bit w1, logic [XLEN-1:0] a1, logic [XLEN-1:0] d1,
                                bit [1:0] g, bit mwe, bit [1:0] rv, bit [1:0] re,
                                bit [1:0] crd, logic [XLEN-1:0] rd0, logic [XLEN-1:0] rd1);
        vec_t v;
        v.tbl = 1'b1; v.rst = rst;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g = g; v.mwe = mwe; v.rv = rv; v.re = re;
        v.crd = crd; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: owner / unbounded streak / most recent grantee
    // ------------------------------------------------------------------
    int              m_owner  = -1;
    int              m_streak = 0;
    int              m_last   = 1;
    logic [XLEN-1:0] ref_mem [DEPTH] = '{default: '0};
    bit   [1:0]      m_rv = '0;
    bit   [1:0]      m_re = '0;
    logic [XLEN-1:0] m_rd [2] = '{default: '0};

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    function automatic int model_grant(bit rst, bit q0, bit q1);
        bit q [2];
        q[0] = q0; q[1] = q1;
        if (rst) return -1;
        if (m_owner >= 0) begin
            if (q[m_owner] && (!q[1-m_owner] || m_streak < MAX_BURST)) return m_owner;
            if (q[1-m_owner]) return 1 - m_owner;
            return -1;
        end
        if (q0 && q1) return 1 - m_last;
        if (q0) return 0;
        if (q1) return 1;
        return -1;
    endfunction

    task automatic run_cycle(input vec_t v);
        int              g;
        bit [1:0]        gv;
        bit              inr;
        logic [XLEN-1:0] ea, ed;
        bit              ewe;

        @(negedge clock);
        reset    = v.rst;
        req[0]   = v.r0; we[0] = v.w0; addr[0] = v.a0; wdata[0] = v.d0;
        req[1]   = v.r1; we[1] = v.w1; addr[1] = v.a1; wdata[1] = v.d1;
        #1;
        g   = model_grant(v.rst, v.r0, v.r1);
        gv  = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        inr = (g >= 0) ? (addr[g] < XLEN'(DEPTH)) : 1'b0;
        ea  = (g >= 0) ? addr[g]  : '0;
        ed  = (g >= 0) ? wdata[g] : '0;
        ewe = (g >= 0) ? (we[g] && inr) : 1'b0;

        chk("gnt",       32'({gnt_1, gnt_0}), 32'(gv));
        chk("mem_addr",  mem_address,         ea);
        chk("mem_wdata", mem_write_data,      ed);
        chk("mem_we",    32'(mem_write_enable), 32'(ewe));
        if (v.rst) begin
            chk("rst_rvalid", 32'({rvalid_1, rvalid_0}), 32'd0);
            chk("rst_rerr",   32'({rerr_1, rerr_0}),     32'd0);
        end
        if (v.tbl) begin
            chk("tbl_gnt", 32'({gnt_1, gnt_0}),   32'(v.g));
            chk("tbl_mwe", 32'(mem_write_enable), 32'(v.mwe));
        end

        // Advance the model across the edge.
        if (v.rst) begin
            m_owner = -1; m_streak = 0; m_last = 1;
            m_rv = '0; m_re = '0; m_rd[0] = '0; m_rd[1] = '0;
        end else begin
            m_rv = '0; m_re = '0;
            if (g >= 0) begin
                if (!we[g]) begin
                    m_rv[g] = 1'b1;
                    m_rd[g] = inr ? ref_mem[addr[g][5:0]] : '0;
                end else if (inr) begin
                    ref_mem[addr[g][5:0]] = wdata[g];
                end
                if (!inr) m_re[g] = 1'b1;
                m_streak = (g == m_owner) ? m_streak + 1 : 1;
                m_owner  = g;
                m_last   = g;
            end else begin
                m_owner  = -1;
                m_streak = 0;
            end
        end

        @(posedge clock);
        #1;
        chk("rvalid", 32'({rvalid_1, rvalid_0}), 32'(m_rv));
        chk("rerr",   32'({rerr_1, rerr_0}),     32'(m_re));
        chk("rdata0", rdata_0, m_rd[0]);
        chk("rdata1", rdata_1, m_rd[1]);
        if (v.tbl) begin
            chk("tbl_rvalid", 32'({rvalid_1, rvalid_0}), 32'(v.rv));
            chk("tbl_rerr",   32'({rerr_1, rerr_0}),     32'(v.re));
            if (v.crd[0]) chk("tbl_rdata0", rdata_0, v.rd0);
            if (v.crd[1]) chk("tbl_rdata1", rdata_1, v.rd1);
        end
        cyc++;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    vec_t tv [$];

    initial begin
        bit [1:0] pat [9];
        vec_t     rv;

        req[0] = 0; req[1] = 0; we[0] = 0; we[1] = 0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

        pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

        // Write then read back on port 0; requests during reset are ignored.
        tv.push_back(mk(1, 1,0,0,0,            1,0,0,0, 2'b00,0, 2'b00,2'b00, 2'b11, 0, 0));
        tv.push_back(mk(0, 1,1,5,32'hDEADBEEF, 0,0,0,0, 2'b01,1, 2'b00,2'b00, 2'b00, 0, 0));
        tv.push_back(mk(0, 1,0,5,0,            0,0,0,0, 2'b01,0, 2'b01,2'b00, 2'b01, 32'hDEADBEEF, 0));
        tv.push_back(mk(0, 0,0,0,0,            0,0,0,0, 2'b00,0, 2'b00,2'b00, 2'b11, 32'hDEADBEEF, 0));

        // Both requesting from IDLE: bursts of four, port 0 first.
        tv.push_back(mk(1, 0,0,0,0, 0,0,0,0, 2'b00,0, 2'b00,2'b00, 2'b11, 0, 0));
        for (int i = 0; i < 9; i++)
            tv.push_back(mk(0, 1,0,5,0, 1,0,6,0, pat[i],0, pat[i],2'b00, pat[i], 32'hDEADBEEF, 0));
        tv.push_back(mk(0, 0,0,0,0, 0,0,0,0, 2'b00,0, 2'b00,2'b00, 2'b00, 0, 0));

        // Lone port 1 streams; saturated count hands over as soon as port 0 asks.
        tv.push_back(mk(1, 0,0,0,0, 0,0,0,0, 2'b00,0, 2'b00,2'b00, 2'b11, 0, 0));
        for (int i = 0; i < 10; i++)
            tv.push_back(mk(0, 0,0,0,0, 1,0,7,0, 2'b10,0, 2'b10,2'b00, 2'b10, 0, 0));
        tv.push_back(mk(0, 1,0,5,0, 1,0,7,0, 2'b01,0, 2'b01,2'b00, 2'b01, 32'hDEADBEEF, 0));
        tv.push_back(mk(0, 0,0,0,0, 0,0,0,0, 2'b00,0, 2'b00,2'b00, 2'b00, 0, 0));

        // Out-of-range read and write on port 1.
        tv.push_back(mk(0, 0,0,0,0, 1,1,7,32'hCAFEF00D,   2'b10,1, 2'b00,2'b00, 2'b00, 0, 0));
        tv.push_back(mk(0, 0,0,0,0, 1,0,7,0,              2'b10,0, 2'b10,2'b00, 2'b10, 0, 32'hCAFEF00D));
        tv.push_back(mk(0, 0,0,0,0, 1,0,64,0,             2'b10,0, 2'b10,2'b10, 2'b10, 0, 0));
        tv.push_back(mk(0, 0,0,0,0, 1,1,100,32'h12345678, 2'b10,0, 2'b00,2'b10, 2'b10, 0, 0));
        tv.push_back(mk(0, 0,0,0,0, 1,0,36,0,             2'b10,0, 2'b10,2'b00, 2'b10, 0, 0));
        tv.push_back(mk(0, 0,0,0,0, 1,0,7,0,              2'b10,0, 2'b10,2'b00, 2'b10, 0, 32'hCAFEF00D));

        // Reset the cycle after a read grant drops the response.
        tv.push_back(mk(1, 0,0,0,0, 0,0,0,0, 2'b00,0, 2'b00,2'b00, 2'b11, 0, 0));
        tv.push_back(mk(0, 1,0,5,0, 0,0,0,0, 2'b01,0, 2'b01,2'b00, 2'b01, 32'hDEADBEEF, 0));
        tv.push_back(mk(1, 1,0,5,0, 1,0,7,0, 2'b00,0, 2'b00,2'b00, 2'b11, 0, 0));
        tv.push_back(mk(0, 1,0,5,0, 1,0,7,0, 2'b01,0, 2'b01,2'b00, 2'b11, 32'hDEADBEEF, 0));

        foreach (tv[i]) run_cycle(tv[i]);

        // Random traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            rv = mk(0, 0,0,0,0, 0,0,0,0, 2'b00,0, 2'b00,2'b00, 2'b00, 0, 0);
            rv.tbl = 1'b0;
            rv.rst = ($urandom_range(0, 59) == 0);
            rv.r0  = ($urandom_range(0, 3) != 0);
            rv.r1  = ($urandom_range(0, 3) != 0);
            rv.w0  = ($urandom_range(0, 2) == 0);
            rv.w1  = ($urandom_range(0, 2) == 0);
            rv.a0  = XLEN'($urandom_range(0, 79));
            rv.a1  = XLEN'($urandom_range(0, 79));
            rv.d0  = $urandom;
            rv.d1  = $urandom;
            run_cycle(rv);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
